// File: rtl/snake_body_walker.sv
// snake_body_walker: drives the recirculating direction ring that stores the
// snake body, inserts new head directions, and walks the body head-to-tail
// reconstructing each segment's grid cell and testing it against a query cell.
module snake_body_walker #(
  parameter int DEPTH = 220,
  parameter int XW    = 4,
  parameter int YW    = 4,
  parameter int LW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    sr_out,
  output logic [1:0]    sr_in,
  input  logic          start,
  input  logic          push,
  input  logic [1:0]    new_dir,
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  input  logic [LW-1:0] length,
  input  logic [XW-1:0] query_x,
  input  logic [YW-1:0] query_y,
  output logic          busy,
  output logic          seg_valid,
  output logic [LW-1:0] seg_idx,
  output logic [XW-1:0] seg_x,
  output logic [YW-1:0] seg_y,
  output logic          done,
  output logic          hit
);

  typedef enum logic [2:0] {
    IDLE,
    INSERT,
    WAIT0,
    SCAN,
    DONE
  } state_t;

  localparam logic [LW-1:0] LAST = LW'(DEPTH - 1);

  state_t        state;
  state_t        next_state;
  logic [LW-1:0] ph;
  logic          pend_start;
  logic [1:0]    dir_lat;
  logic [LW-1:0] len_lat;
  logic [XW-1:0] qx_lat;
  logic [YW-1:0] qy_lat;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [XW-1:0] nxt_x;
  logic [YW-1:0] nxt_y;
  logic          hit_acc;
  logic          match;
  logic          take_push;
  logic          take_start;
  logic          insert_now;
  logic          scan_last;

  assign busy  = (state != IDLE);
  assign match = (cur_x == qx_lat) && (cur_y == qy_lat);

  // The ring recirculates except on the single insert cycle; reset forces
  // pure recirculation so an aborted insert never corrupts the body.
  assign sr_in = (rst_n && insert_now) ? dir_lat : sr_out;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and the per-cycle control strobes derived from it.
  always_comb begin
    next_state = state;
    take_push  = 1'b0;
    take_start = 1'b0;
    insert_now = 1'b0;
    scan_last  = 1'b0;
    case (state)
      IDLE: begin
        if (push) begin
          next_state = INSERT;
          take_push  = 1'b1;
          take_start = start;
        end else if (start) begin
          next_state = WAIT0;
          take_start = 1'b1;
        end
      end
      INSERT: begin
        if (ph == LAST) begin
          insert_now = 1'b1;
          next_state = pend_start ? WAIT0 : IDLE;
        end
      end
      WAIT0: begin
        if (len_lat == '0)     next_state = DONE;
        else if (ph == LAST)   next_state = SCAN;
      end
      SCAN: begin
        if (ph == len_lat - LW'(1)) begin
          scan_last  = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Phase counter tracks which body index is leaving the ring; an insert
  // skips phase 0 so every old segment is renumbered one further from the head.
  always_ff @(posedge clk) begin
    if (!rst_n)           ph <= '0;
    else if (insert_now)  ph <= LW'(1);
    else if (ph == LAST)  ph <= '0;
    else                  ph <= ph + LW'(1);
  end

  // Step back from segment k to segment k+1 by undoing dir[k].
  always_comb begin
    nxt_x = cur_x;
    nxt_y = cur_y;
    case (sr_out)
      2'd0:    nxt_x = cur_x - XW'(1);
      2'd1:    nxt_y = cur_y - YW'(1);
      2'd2:    nxt_x = cur_x + XW'(1);
      default: nxt_y = cur_y + YW'(1);
    endcase
  end

  // Request latches, scan accumulator and registered segment/result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_start <= 1'b0;
      dir_lat    <= '0;
      len_lat    <= '0;
      qx_lat     <= '0;
      qy_lat     <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      hit_acc    <= 1'b0;
      seg_valid  <= 1'b0;
      seg_idx    <= '0;
      seg_x      <= '0;
      seg_y      <= '0;
      done       <= 1'b0;
      hit        <= 1'b0;
    end else begin
      seg_valid <= 1'b0;
      done      <= 1'b0;
      if (take_push) begin
        dir_lat    <= new_dir;
        pend_start <= start;
      end
      if (insert_now) pend_start <= 1'b0;
      if (take_start) begin
        cur_x   <= head_x;
        cur_y   <= head_y;
        qx_lat  <= query_x;
        qy_lat  <= query_y;
        len_lat <= (length > LAST) ? LAST : length;
        hit_acc <= 1'b0;
      end
      if (state == SCAN) begin
        seg_valid <= 1'b1;
        seg_idx   <= ph;
        seg_x     <= cur_x;
        seg_y     <= cur_y;
        cur_x     <= nxt_x;
        cur_y     <= nxt_y;
        hit_acc   <= hit_acc | match;
        if (scan_last) begin
          done <= 1'b1;
          hit  <= hit_acc | match;
        end
      end
      if (state == WAIT0 && len_lat == '0) begin
        done <= 1'b1;
        hit  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snake_body_walker.sv
// tb_snake_body_walker: directed bench with an attached 8-slot direction ring
// and a scoreboard of expected segment reports.
module tb_snake_body_walker;

  localparam int DEPTH = 8;
  localparam int XW    = 4;
  localparam int YW    = 4;
  localparam int LW    = 8;

  logic          clk;
  logic          rst_n;
  logic [1:0]    sr_out;
  logic [1:0]    sr_in;
  logic          start;
  logic          push;
  logic [1:0]    new_dir;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] length;
  logic [XW-1:0] query_x;
  logic [YW-1:0] query_y;
  logic          busy;
  logic          seg_valid;
  logic [LW-1:0] seg_idx;
  logic [XW-1:0] seg_x;
  logic [YW-1:0] seg_y;
  logic          done;
  logic          hit;

  logic [1:0]           ring [DEPTH];
  logic                 load_en;
  logic [2*DEPTH-1:0]   load_dirs;

  typedef struct packed {
    logic       zl;
    logic [7:0] idx;
    logic [3:0] x;
    logic [3:0] y;
    logic       last;
    logic       hit;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  logic saw_idx2;

  snake_body_walker #(.DEPTH(DEPTH), .XW(XW), .YW(YW), .LW(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sr_out    (sr_out),
    .sr_in     (sr_in),
    .start     (start),
    .push      (push),
    .new_dir   (new_dir),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .query_x   (query_x),
    .query_y   (query_y),
    .busy      (busy),
    .seg_valid (seg_valid),
    .seg_idx   (seg_idx),
    .seg_x     (seg_x),
    .seg_y     (seg_y),
    .done      (done),
    .hit       (hit)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Attached shift register; slot DEPTH-1 leaves first. load_dirs holds dir[k]
  // in bits [2k+:2] and is aligned so dir[0] leaves on the cycle with ph == 0.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= load_dirs[2*(DEPTH-1-i) +: 2];
    end else begin
      ring[0] <= sr_in;
      for (int i = 1; i < DEPTH; i++) ring[i] <= ring[i-1];
    end
  end

  assign sr_out = ring[DEPTH-1];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic exp_seg(input logic [7:0] idx, input logic [3:0] x, input logic [3:0] y,
                         input logic last, input logic h);
    exp_t e;
    e.zl = 1'b0; e.idx = idx; e.x = x; e.y = y; e.last = last; e.hit = h;
    exp_q.push_back(e);
  endtask

  task automatic exp_zero_len();
    exp_t e;
    e.zl = 1'b1; e.idx = '0; e.x = '0; e.y = '0; e.last = 1'b1; e.hit = 1'b0;
    exp_q.push_back(e);
  endtask

  // Advance one clock and score any segment/done report at the falling edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (seg_valid === 1'b1 || done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_output", 32'(seg_valid) + 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("seg_valid", 32'(seg_valid), 32'(!e.zl));
        if (!e.zl) begin
          check_output("seg_idx", 32'(seg_idx), 32'(e.idx));
          check_output("seg_x", 32'(seg_x), 32'(e.x));
          check_output("seg_y", 32'(seg_y), 32'(e.y));
          if (seg_idx == 8'd2) saw_idx2 = 1'b1;
        end
        check_output("done", 32'(done), 32'(e.last));
        if (e.last) check_output("hit", 32'(hit), 32'(e.hit));
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (busy === 1'b0) break;
    end
    check_output(tag, 32'(busy), 32'd0);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_stimulus(input logic [3:0] hx, input logic [3:0] hy, input logic [7:0] len,
                                input logic [3:0] qx, input logic [3:0] qy,
                                input logic do_start, input logic do_push, input logic [1:0] nd);
    head_x = hx; head_y = hy; length = len; query_x = qx; query_y = qy;
    start = do_start; push = do_push; new_dir = nd;
    step();
    start = 1'b0; push = 1'b0;
  endtask

  task automatic reset_load(input logic [2*DEPTH-1:0] dirs);
    rst_n = 1'b0; load_en = 1'b0;
    step();
    load_dirs = dirs; load_en = 1'b1;
    step();
    load_en = 1'b0; rst_n = 1'b1;
  endtask

  function automatic logic [2*DEPTH-1:0] ring_bits();
    logic [2*DEPTH-1:0] r;
    for (int i = 0; i < DEPTH; i++) r[2*i +: 2] = ring[i];
    return r;
  endfunction

  // Directed sequence.
  initial begin
    logic [2*DEPTH-1:0] snap;
    int ones;
    checks = 0; errors = 0; saw_idx2 = 1'b0;
    rst_n = 1'b0; start = 1'b0; push = 1'b0; new_dir = '0;
    head_x = '0; head_y = '0; length = '0; query_x = '0; query_y = '0;
    load_en = 1'b0; load_dirs = '0;

    reset_load('0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_seg_valid", 32'(seg_valid), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_hit", 32'(hit), 32'd0);
    check_output("rst_seg_idx", 32'(seg_idx), 32'd0);
    check_output("rst_seg_x", 32'(seg_x), 32'd0);
    check_output("rst_seg_y", 32'(seg_y), 32'd0);
    step();
    check_output("idle_recirc", 32'(sr_in), 32'(sr_out));

    $display("[TB] basic scan, all-zero ring");
    exp_seg(8'd0, 4'd5, 4'd5, 1'b0, 1'b0);
    exp_seg(8'd1, 4'd4, 4'd5, 1'b0, 1'b0);
    exp_seg(8'd2, 4'd3, 4'd5, 1'b1, 1'b1);
    apply_stimulus(4'd5, 4'd5, 8'd3, 4'd4, 4'd5, 1'b1, 1'b0, 2'd0);
    check_output("busy_after_start", 32'(busy), 32'd1);
    wait_idle("basic_idle", 40);
    check_output("basic_hit_held", 32'(hit), 32'd1);

    $display("[TB] zero length scan");
    exp_zero_len();
    apply_stimulus(4'd1, 4'd1, 8'd0, 4'd1, 4'd1, 1'b1, 1'b0, 2'd0);
    wait_idle("zero_idle", 40);
    check_output("zero_hit", 32'(hit), 32'd0);

    $display("[TB] wrap-around scan");
    exp_seg(8'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    exp_seg(8'd1, 4'd15, 4'd0, 1'b0, 1'b0);
    exp_seg(8'd2, 4'd14, 4'd0, 1'b1, 1'b1);
    apply_stimulus(4'd0, 4'd0, 8'd3, 4'd14, 4'd0, 1'b1, 1'b0, 2'd0);
    wait_idle("wrap_idle", 40);

    $display("[TB] push then scan");
    apply_stimulus(4'd0, 4'd0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, 2'd1);
    check_output("busy_after_push", 32'(busy), 32'd1);
    wait_idle("push_idle", 40);
    check_output("hit_held_over_push", 32'(hit), 32'd1);
    ones = 0;
    for (int i = 0; i < DEPTH; i++) if (ring[i] == 2'd1) ones++;
    check_output("ring_one_insert", 32'(ones), 32'd1);
    exp_seg(8'd0, 4'd5, 4'd6, 1'b0, 1'b0);
    exp_seg(8'd1, 4'd5, 4'd5, 1'b0, 1'b0);
    exp_seg(8'd2, 4'd4, 4'd5, 1'b0, 1'b0);
    exp_seg(8'd3, 4'd3, 4'd5, 1'b1, 1'b0);
    apply_stimulus(4'd5, 4'd6, 8'd4, 4'd9, 4'd9, 1'b1, 1'b0, 2'd0);
    wait_idle("push_scan_idle", 40);

    $display("[TB] push and start together, start while busy");
    exp_seg(8'd0, 4'd2, 4'd2, 1'b0, 1'b0);
    exp_seg(8'd1, 4'd2, 4'd3, 1'b0, 1'b0);
    exp_seg(8'd2, 4'd2, 4'd2, 1'b1, 1'b1);
    apply_stimulus(4'd2, 4'd2, 8'd3, 4'd2, 4'd2, 1'b1, 1'b1, 2'd3);
    check_output("busy_after_both", 32'(busy), 32'd1);
    step();
    apply_stimulus(4'd7, 4'd7, 8'd2, 4'd7, 4'd7, 1'b1, 1'b0, 2'd0);
    wait_idle("both_idle", 40);
    for (int i = 0; i < 20; i++) step();
    check_output("no_extra_scan", 32'(exp_q.size()) + 32'(busy), 32'd0);

    $display("[TB] patterned ring, insert, clamped length");
    reset_load({2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2});
    apply_stimulus(4'd0, 4'd0, 8'd0, 4'd0, 4'd0, 1'b0, 1'b1, 2'd1);
    wait_idle("pat_push_idle", 40);
    exp_seg(8'd0, 4'd8, 4'd8, 1'b0, 1'b0);
    exp_seg(8'd1, 4'd8, 4'd7, 1'b0, 1'b0);
    exp_seg(8'd2, 4'd9, 4'd7, 1'b0, 1'b0);
    exp_seg(8'd3, 4'd9, 4'd8, 1'b0, 1'b0);
    exp_seg(8'd4, 4'd8, 4'd8, 1'b0, 1'b0);
    exp_seg(8'd5, 4'd8, 4'd7, 1'b0, 1'b0);
    exp_seg(8'd6, 4'd9, 4'd7, 1'b1, 1'b1);
    apply_stimulus(4'd8, 4'd8, 8'd200, 4'd9, 4'd8, 1'b1, 1'b0, 2'd0);
    wait_idle("clamp_idle", 40);

    $display("[TB] reset during scan");
    saw_idx2 = 1'b0;
    exp_seg(8'd0, 4'd3, 4'd3, 1'b0, 1'b0);
    exp_seg(8'd1, 4'd3, 4'd2, 1'b0, 1'b0);
    exp_seg(8'd2, 4'd4, 4'd2, 1'b0, 1'b0);
    apply_stimulus(4'd3, 4'd3, 8'd7, 4'd0, 4'd0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (saw_idx2) break;
    end
    check_output("reached_idx2", 32'(saw_idx2), 32'd1);
    snap = ring_bits();
    rst_n = 1'b0;
    step();
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_seg_valid", 32'(seg_valid), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_hit", 32'(hit), 32'd0);
    check_output("abort_seg_fields", 32'(seg_idx) + 32'(seg_x) + 32'(seg_y), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH - 2; i++) step();
    check_output("ring_unchanged", 32'(ring_bits()), 32'(snap));
    check_output("abort_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_body_walker.md
Name: snake_body_walker

Overview:
- Controller and consumer for the recirculating direction shift register that holds the snake body.
- Drives the register's data input. It normally recirculates the register's output, and inserts a new head direction on request.
- Walks the body from head to tail, reconstructing each segment's grid coordinates. Reports each segment, and whether any segment matches a query cell, to the game logic and renderer.

Parameters:
- DEPTH, 220, depth of the attached direction shift register (slots in the ring).
- XW, 4, x coordinate width; grid x wraps modulo 2^XW.
- YW, 4, y coordinate width; grid y wraps modulo 2^YW.
- LW, 8, width of length and index fields; must satisfy 2^LW > DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- sr_out  in  2  direction leaving the shift register this cycle
- sr_in  out  2  direction entering the shift register this cycle
- start  in  1  pulse: begin a body scan
- push  in  1  pulse: insert new_dir as the new head direction
- new_dir  in  2  direction to insert with push
- head_x  in  XW  head x; sampled with start
- head_y  in  YW  head y; sampled with start
- length  in  LW  segment count; sampled with start
- query_x  in  XW  compare cell x; sampled with start
- query_y  in  YW  compare cell y; sampled with start
- busy  out  1  high whenever state is not IDLE
- seg_valid  out  1  seg_* fields valid this cycle
- seg_idx  out  LW  segment index, 0 = head
- seg_x  out  XW  segment x
- seg_y  out  YW  segment y
- done  out  1  one-cycle pulse at scan end
- hit  out  1  result of the last scan; held until the next scan ends

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous, active low.
- Direction code: 0 = +x, 1 = +y, 2 = -x, 3 = -y. dir[k] is the step from segment k+1 to segment k.
  - Position of segment k+1 = position of segment k minus the vector of dir[k].
  - Subtraction is modulo 2^XW / 2^YW (wrap-around, no clamping).
- Phase counter ph (LW bits) advances every cycle, including in IDLE. sr_out carries dir[ph].
  - Normal wrap is DEPTH-1 -> 0.
- sr_in equals sr_out on every cycle except an insert cycle.
- Insert: performed on the first cycle in INSERT with ph == DEPTH-1.
  - sr_in = new_dir (latched at push); the old slot DEPTH-1 is discarded.
  - Next ph = 1 instead of 0, so old segment k becomes k+1 and new_dir becomes segment 0.
- Length is clamped to DEPTH-1, so the discarded slot is never live.
- States:
  - IDLE -> INSERT on push.
  - IDLE -> WAIT0 on start (without push).
  - Push and start in the same cycle: both latched, INSERT runs first, then WAIT0 automatically.
  - INSERT -> IDLE, or -> WAIT0 if a start is pending, after the insert cycle.
  - WAIT0 -> SCAN when ph == 0. If the latched length is 0, WAIT0 -> DONE immediately instead.
  - SCAN -> DONE after the cycle with ph == length-1.
  - DONE -> IDLE after one cycle.
- start and push are ignored while busy == 1.
- Scan accumulator: cur = head on the ph == 0 cycle; each SCAN cycle, cur <= cur - vec(sr_out).
- Segment outputs are registered with one-cycle latency.
  - The cycle after SCAN at ph == k: seg_valid = 1, seg_idx = k, seg_x/seg_y = position of segment k.
- hit:
  - Accumulates the OR of (segment == query) over segments 0..length-1.
  - Updated in the same cycle as done.
  - done coincides with the last seg_valid.
  - Length 0: done occurs one cycle after leaving WAIT0, with hit = 0.
- Reset:
  - ph = 0, state IDLE, pending flags cleared.
  - busy, seg_valid, done, hit, seg_idx, seg_x and seg_y are all 0.
  - sr_in stays a pure recirculation of sr_out.
  - Shift register contents are not reset.
- Reset asserted mid-insert or mid-scan: the operation is aborted, no done pulse is issued, and ring contents are left as they were.

Test Plan:
- Common setup: DEPTH = 8, XW = YW = 4, bench shift register attached.
- Ring loaded with dir = 0 for all slots; start with head (5,5), length 3, query (4,5):
  - seg_valid for 3 cycles: (5,5) idx 0, (4,5) idx 1, (3,5) idx 2.
  - done with the third; hit = 1.
- Same ring; push new_dir = 1, then start with head (5,6), length 4, query (9,9):
  - Segments (5,6), (5,5), (4,5), (3,5); hit = 0.
  - After exactly DEPTH cycles, the ring holds the old contents shifted by one slot.
- Wrap-around: head (0,0), dir = 0, length 3 -> segments (0,0), (15,0), (14,0).
- Length 0 start -> done one cycle after WAIT0 exits, no seg_valid, hit = 0.
- Length 200 -> clamped; exactly 7 seg_valid pulses, idx 0..6.
- Push and start in the same cycle:
  - Insert completes before any seg_valid.
  - A start issued while busy produces no extra scan.
- rst_n low mid-scan -> all outputs 0 next cycle, no done, ring contents unchanged.
